// File: rtl/pim_host_sequencer.sv
// Host-side sequencer for the processing-in-memory block.
// It queues host commands and issues them one at a time over the
// instruction / operation_enable / ready handshake. For flagged commands it
// captures the PIM data output into a first-word-fall-through result FIFO.
module pim_host_sequencer #(
  parameter int CMD_DEPTH      = 8,
  parameter int RSP_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [44:0] cmd_instr,
  input  logic        cmd_expect,
  output logic [44:0] pim_instruction,
  output logic        pim_operation_enable,
  input  logic        pim_ready,
  input  logic [31:0] pim_data_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] issued_count
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CAW:0]  CMD_FULL   = (CAW + 1)'(CMD_DEPTH);
  localparam logic [RAW:0]  RSP_FULL   = (RAW + 1)'(RSP_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Command FIFO: entry = {expect, instr}
  // ---------------------------------------------------------------------------
  logic [45:0]    cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr;
  logic [CAW-1:0] cmd_rd_ptr;
  logic [CAW:0]   cmd_count;
  logic [45:0]    cmd_head;
  logic           cmd_push;
  logic           cmd_empty;

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]    rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr;
  logic [RAW-1:0] rsp_rd_ptr;
  logic [RAW:0]   rsp_count;
  logic           rsp_full;
  logic           rsp_push;
  logic           rsp_pop;

  // ---------------------------------------------------------------------------
  // Sequencer bookkeeping
  // ---------------------------------------------------------------------------
  logic          held_expect;
  logic [TW-1:0] timer;
  logic          timer_expired;
  logic          take_cmd;

  assign cmd_empty = (cmd_count == '0);
  assign cmd_ready = (cmd_count != CMD_FULL);
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_head  = cmd_mem[cmd_rd_ptr];

  assign rsp_full  = (rsp_count == RSP_FULL);
  assign rsp_valid = (rsp_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  // Space for the capture is reserved before issue; the pop term lets a
  // capture into a full FIFO coincide with a host pop.
  assign rsp_push  = (state == CAPTURE) && (!rsp_full || rsp_pop);
  // Storage is not reset, so the head is masked to zero while empty.
  assign rsp_data  = rsp_valid ? rsp_mem[rsp_rd_ptr] : 32'd0;

  // A result-producing command waits in IDLE until the result FIFO has room,
  // so a capture can never be dropped.
  assign take_cmd = (state == IDLE) && !cmd_empty && pim_ready &&
                    (!cmd_head[45] || !rsp_full);

  assign timer_expired = (timer == TIMER_LAST);

  assign busy = (state != IDLE) || !cmd_empty;

  // Command FIFO storage write.
  // NOTE: FIFO storage is deliberately left out of reset; the pointers and
  // occupancy counter alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr] <= {cmd_expect, cmd_instr};
    end
  end

  // Command FIFO pointers and occupancy.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) begin
        cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
      end
      if (take_cmd) begin
        cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
      end
      case ({cmd_push, take_cmd})
        2'b10:   cmd_count <= cmd_count + (CAW + 1)'(1);
        2'b01:   cmd_count <= cmd_count - (CAW + 1)'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // Result FIFO storage write.
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr] <= pim_data_out;
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) begin
        rsp_wr_ptr <= rsp_wr_ptr + RAW'(1);
      end
      if (rsp_pop) begin
        rsp_rd_ptr <= rsp_rd_ptr + RAW'(1);
      end
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + (RAW + 1)'(1);
        2'b01:   rsp_count <= rsp_count - (RAW + 1)'(1);
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // Issue FSM with registered handshake outputs, timeout watchdog and
  // completion counter. The instruction register doubles as the holding
  // register, so the PIM sees a stable value from ISSUE until the next ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      pim_instruction      <= '0;
      pim_operation_enable <= 1'b0;
      held_expect          <= 1'b0;
      timer                <= '0;
      timeout_err          <= 1'b0;
      issued_count         <= '0;
    end else begin
      pim_operation_enable <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (take_cmd) begin
            pim_instruction      <= cmd_head[44:0];
            held_expect          <= cmd_head[45];
            pim_operation_enable <= 1'b1;
            state                <= ISSUE;
          end
        end

        ISSUE: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (!pim_ready) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timer_expired) begin
            timer        <= '0;
            timeout_err  <= 1'b1;
            issued_count <= issued_count + 16'd1;
            state        <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        WAIT_DONE: begin
          if (pim_ready) begin
            timer <= '0;
            if (held_expect) begin
              state <= CAPTURE;
            end else begin
              issued_count <= issued_count + 16'd1;
              state        <= IDLE;
            end
          end else if (timer_expired) begin
            timer        <= '0;
            timeout_err  <= 1'b1;
            issued_count <= issued_count + 16'd1;
            state        <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        CAPTURE: begin
          timer        <= '0;
          issued_count <= issued_count + 16'd1;
          state        <= IDLE;
        end

        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
